// File: rtl/booth_pipe_ctrl.sv
// rtl/booth_pipe_ctrl.sv - latch-strobe sequencer for Booth multiplier pipeline stages
module booth_pipe_ctrl #(
    parameter int NUM_STAGES  = 4,
    parameter int STAGE_DELAY = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [NUM_STAGES-1:0]             lt,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [$clog2(NUM_STAGES+1)-1:0]   occupancy,
    output logic                              busy
);
    localparam int N     = NUM_STAGES;
    localparam int OCC_W = $clog2(NUM_STAGES+1);
    localparam int CNT_W = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STAGE_DELAY - 1);

    logic [N-1:0]     r_occ;
    logic [CNT_W-1:0] r_cnt [N];
    logic [N-1:0]     r_lt;
    logic [OCC_W-1:0] r_occupancy;
    logic             r_run;

    logic [N-1:0]     w_set;
    logic [N-1:0]     w_adv;
    logic [N-1:0]     w_load;
    logic [N-1:0]     w_occ_nxt;
    logic [OCC_W-1:0] w_pop;
    logic             w_acc;

    always_comb begin
        w_set = '0;
        for (int i = 0; i < N; i++) begin
            w_set[i] = r_occ[i] & (r_cnt[i] == '0);
        end
    end

    // Advance chain resolved top-down: a stage may move if the one above is empty or moving too.
    always_comb begin
        logic v_chain;
        w_adv      = '0;
        v_chain    = w_set[N-1] & out_ready & ~flush;
        w_adv[N-1] = v_chain;
        for (int i = N-2; i >= 0; i--) begin
            v_chain  = w_set[i] & (~r_occ[i+1] | v_chain) & ~flush;
            w_adv[i] = v_chain;
        end
    end

    assign in_ready = r_run & ~flush & (~r_occ[0] | w_adv[0]);
    assign w_acc    = in_valid & in_ready;
    assign w_load   = {w_adv[N-2:0], w_acc};

    always_comb begin
        w_occ_nxt = flush ? '0 : ((r_occ & ~w_adv) | w_load);
        w_pop     = '0;
        for (int i = 0; i < N; i++) begin
            w_pop = w_pop + OCC_W'(w_occ_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run       <= 1'b0;
            r_occ       <= '0;
            r_lt        <= '0;
            r_occupancy <= '0;
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_run       <= 1'b1;
            r_occ       <= w_occ_nxt;
            r_lt        <= flush ? '0 : w_load;
            r_occupancy <= w_pop;
            for (int i = 0; i < N; i++) begin
                if (flush) begin
                    r_cnt[i] <= '0;
                end else if (w_load[i]) begin
                    r_cnt[i] <= CNT_LOAD;
                end else if (r_occ[i] && (r_cnt[i] != '0)) begin
                    r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    assign lt        = r_lt;
    assign out_valid = w_set[N-1];
    assign occupancy = r_occupancy;
    assign busy      = (r_occupancy != '0);

endmodule

// File: tb/tb_booth_pipe_ctrl.sv
// tb/tb_booth_pipe_ctrl.sv - timestamp-model bench for booth_pipe_ctrl
module tb_booth_pipe_ctrl;
    localparam int N = 4;
    localparam int D = 2;
    localparam int HMAX = 4096;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] lt;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   occupancy;
    logic         busy;

    booth_pipe_ctrl #(.NUM_STAGES(N), .STAGE_DELAY(D)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .lt(lt),
        .out_valid(out_valid), .out_ready(out_ready),
        .occupancy(occupancy), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_acc = 0;
    int n_ret = 0;
    int acc_q[$];
    int ret_q[$];
    logic [N-1:0] hist_lt [HMAX];
    bit           hist_ov [HMAX];
    bit           hist_ir [HMAX];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: each stage remembers the cycle it was loaded; it is settled D cycles later.
    logic [N-1:0] m_occ = '0;
    logic [N-1:0] m_lt  = '0;
    logic [N-1:0] m_set;
    logic [N-1:0] m_go;
    int           m_ld [N];
    bit           m_run = 1'b0;
    bit           e_ir, e_ov, m_acc;

    always begin
        @(negedge clk);
        #4;
        if (!rst_n) begin
            chk("rst_in_ready", int'(in_ready), 0);
            chk("rst_lt", int'(lt), 0);
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_occupancy", int'(occupancy), 0);
            chk("rst_busy", int'(busy), 0);
            m_occ = '0;
            m_lt  = '0;
            m_run = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) m_set[i] = m_occ[i] && (cyc - m_ld[i] >= D);
            m_go = '0;
            if (!flush) begin
                m_go[N-1] = m_set[N-1] && out_ready;
                for (int i = N-2; i >= 0; i--) m_go[i] = m_set[i] && (!m_occ[i+1] || m_go[i+1]);
            end
            e_ir = m_run && !flush && (!m_occ[0] || m_go[0]);
            e_ov = m_set[N-1];
            chk("in_ready", int'(in_ready), int'(e_ir));
            chk("out_valid", int'(out_valid), int'(e_ov));
            chk("lt", int'(lt), int'(m_lt));
            chk("occupancy", int'(occupancy), $countones(m_occ));
            chk("busy", int'(busy), int'(m_occ != '0));
            m_acc = in_valid && e_ir;
            if (m_acc) begin
                n_acc++;
                acc_q.push_back(cyc);
            end
            if (e_ov && out_ready && !flush) begin
                n_ret++;
                ret_q.push_back(cyc);
            end
            if (flush) begin
                m_occ = '0;
                m_lt  = '0;
            end else begin
                m_occ = m_occ & ~m_go;
                for (int i = 1; i < N; i++) if (m_go[i-1]) begin m_occ[i] = 1'b1; m_ld[i] = cyc; end
                if (m_acc) begin m_occ[0] = 1'b1; m_ld[0] = cyc; end
                m_lt = {m_go[N-2:0], m_acc};
            end
            m_run = 1'b1;
        end
        if (cyc < HMAX) begin
            hist_lt[cyc] = lt;
            hist_ov[cyc] = out_valid;
            hist_ir[cyc] = in_ready;
        end
        cyc++;
    end

    task automatic drive(input bit iv, input bit orr, input bit fl);
        @(negedge clk);
        in_valid  = iv;
        out_ready = orr;
        flush     = fl;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b1, 1'b0);
    endtask

    task automatic run_single(input string tag);
        int c0;
        int nov;
        idle(4);
        drive(1'b1, 1'b1, 1'b0);
        c0 = cyc;
        idle(16);
        chk({tag, "_accept"}, int'(hist_ir[c0]), 1);
        for (int k = 0; k < N; k++) chk({tag, "_lt_pulse"}, int'(hist_lt[c0 + 1 + 2*k]), 1 << k);
        nov = 0;
        for (int c = c0; c < c0 + 14; c++) nov += int'(hist_ov[c]);
        chk({tag, "_ov_count"}, nov, 1);
        chk({tag, "_ov_cycle8"}, int'(hist_ov[c0 + 8]), 1);
    endtask

    initial begin
        int s_acc, s_ret, c_start, viol, rc, qs;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;

        run_single("t1");

        // streaming 8 ops
        s_acc = n_acc; s_ret = n_ret; c_start = cyc;
        for (int k = 0; k < 40; k++) drive(n_acc - s_acc < 8, 1'b1, 1'b0);
        idle(20);
        chk("t2_accepted", n_acc - s_acc, 8);
        chk("t2_retired", n_ret - s_ret, 8);
        qs = acc_q.size();
        for (int k = qs - 7; k < qs; k++) chk("t2_acc_gap", acc_q[k] - acc_q[k-1], D);
        qs = ret_q.size();
        for (int k = qs - 7; k < qs; k++) chk("t2_ret_gap", ret_q[k] - ret_q[k-1], D);
        viol = 0;
        for (int c = c_start; c < cyc - 1; c++) viol += $countones(hist_lt[c] & hist_lt[c+1]);
        chk("t2_lt_overlap", viol, 0);

        // back-pressure fill
        s_acc = n_acc;
        repeat (30) drive(1'b1, 1'b0, 1'b0);
        #1;
        chk("t3_accepted", n_acc - s_acc, 4);
        chk("t3_occupancy", int'(occupancy), 4);
        chk("t3_in_ready", int'(in_ready), 0);
        chk("t3_out_valid", int'(out_valid), 1);
        chk("t3_lt", int'(lt), 0);

        // single-cycle release under full pipe
        s_acc = n_acc; s_ret = n_ret;
        drive(1'b1, 1'b1, 1'b0);
        rc = cyc;
        repeat (20) drive(1'b1, 1'b0, 1'b0);
        #1;
        chk("t4_retired", n_ret - s_ret, 1);
        chk("t4_accepted", n_acc - s_acc, 1);
        chk("t4_occupancy", int'(occupancy), 4);
        chk("t4_lt_all", int'(hist_lt[rc + 1]), 'hF);

        // flush with 3 in flight
        idle(20);
        s_acc = n_acc;
        for (int k = 0; k < 20 && n_acc - s_acc < 3; k++) drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        #1;
        chk("t5_occ_before", int'(occupancy), 3);
        chk("t5_in_ready_flush", int'(in_ready), 0);
        drive(1'b0, 1'b1, 1'b0);
        #1;
        chk("t5_occupancy", int'(occupancy), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_out_valid", int'(out_valid), 0);
        chk("t5_lt", int'(lt), 0);
        chk("t5_accepted", n_acc - s_acc, 3);

        // random traffic
        for (int k = 0; k < 300; k++)
            drive($urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);

        // async reset mid-stream
        repeat ($urandom_range(1, 7)) drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        #($urandom_range(1, 3));
        rst_n = 1'b0;
        #1;
        chk("t6_in_ready", int'(in_ready), 0);
        chk("t6_lt", int'(lt), 0);
        chk("t6_out_valid", int'(out_valid), 0);
        chk("t6_occupancy", int'(occupancy), 0);
        chk("t6_busy", int'(busy), 0);
        repeat (2) drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        run_single("t6");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
        $fatal(1, "watchdog");
    end
endmodule
